// File: rtl/array_sum_master_pkg.sv
// Shared constants and FSM encoding for the array-sum memory initiator.
package array_sum_master_pkg;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_DEPTH = 1000;
  localparam logic [15:0] DATA_MIN  = 16'h8000;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRd,
    StCap,
    StWaddr,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/sat_flag_adder.sv
// Combinational signed adder: wrapped two's-complement sum plus signed-overflow flag.
module sat_flag_adder import array_sum_master_pkg::*; #(
  parameter int unsigned Width = DATA_W
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o,
  output logic             ovf_o
);

  always_comb begin
    sum_o = a_i + b_i;
    // Overflow when operands agree in sign but the result does not.
    ovf_o = (a_i[Width-1] == b_i[Width-1]) && (sum_o[Width-1] != a_i[Width-1]);
  end

endmodule

// File: rtl/array_sum_master.sv
// Walks a block of signed words over the memory strobe interface, accumulating sum and
// maximum, then writes the sum to a destination address and pulses done.
module array_sum_master #(
  parameter int unsigned ADDR_W    = array_sum_master_pkg::ADDR_W,
  parameter int unsigned DATA_W    = array_sum_master_pkg::DATA_W,
  parameter int unsigned MEM_DEPTH = array_sum_master_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] count,
  input  logic [ADDR_W-1:0] dstAddr,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] readData,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] maxVal,
  output logic              overflow,
  output logic              err
);

  import array_sum_master_pkg::*;

  localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W:0]   Depth  = (ADDR_W+1)'(MEM_DEPTH);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_ovf;
  logic [ADDR_W:0]   last_addr;
  logic              range_bad;

  sat_flag_adder #(
    .Width (DATA_W)
  ) u_adder (
    .a_i   (sum_q),
    .b_i   (readData),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // One extra bit so base+count-1 cannot wrap past the depth check.
  assign last_addr = {1'b0, baseAddr} + {1'b0, count} - (ADDR_W+1)'(1);
  assign range_bad = ((count != '0) && (last_addr >= Depth)) || ({1'b0, dstAddr} >= Depth);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (range_bad) begin
            state_d = StDone;
          end else if (count == '0) begin
            state_d = StWaddr;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr:  state_d = StRd;
      StRd:    state_d = StCap;
      StCap:   state_d = (rem_q == ADDR_W'(1)) ? StWaddr : StAddr;
      StWaddr: state_d = StWr;
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are loaded from the state being entered so they line up with it.
  always_comb begin
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sum_d   = sum_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d = baseAddr;
          rem_d = count;
          dst_d = dstAddr;
          sum_d = '0;
          max_d = MinVal;
          ovf_d = 1'b0;
          err_d = range_bad;
        end
      end
      StCap: begin
        ptr_d = ptr_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        sum_d = add_sum;
        ovf_d = ovf_q | add_ovf;
        if ($signed(readData) > $signed(max_q)) begin
          max_d = readData;
        end
      end
      default: ;
    endcase
    if (state_d == StAddr) begin
      addr_d = ptr_d;
    end
    if (state_d == StWaddr) begin
      addr_d  = dst_d;
      wdata_d = sum_d;
    end
    rd_d   = (state_d == StRd);
    wr_d   = (state_d == StWr);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sum_q   <= '0;
      max_q   <= MinVal;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign address   = addr_q;
  assign writeData = wdata_q;
  assign memRead   = rd_q;
  assign memWrite  = wr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign sum       = sum_q;
  assign maxVal    = max_q;
  assign overflow  = ovf_q;
  assign err       = err_q;

endmodule
